// File: rtl/nco_hop_sequencer.sv
// nco_hop_sequencer: walks a table of NCO phase-step words, offering each one
// to the NCO over AXI-Stream and then holding it for that entry's dwell time.
// Runs single-shot or looped, and gates the NCO dither enable for the run.
module nco_hop_sequencer #(
    parameter  int WIDTH       = 32,
    parameter  int DEPTH       = 16,
    parameter  int DWELL_WIDTH = 24,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic                   aclk,
    input  logic                   arst_n,
    input  logic                   cfg_wr_en,
    input  logic [IDX_W-1:0]       cfg_wr_addr,
    input  logic [WIDTH-1:0]       cfg_wr_step,
    input  logic [DWELL_WIDTH-1:0] cfg_wr_dwell,
    input  logic [IDX_W-1:0]       cfg_last_idx,
    input  logic                   cfg_loop,
    input  logic                   cfg_dither,
    input  logic                   start,
    input  logic                   stop,
    output logic [WIDTH-1:0]       m_axis_data_tdata,
    output logic                   m_axis_data_tvalid,
    input  logic                   m_axis_data_tready,
    output logic                   dither_enable,
    output logic                   busy,
    output logic [IDX_W-1:0]       cur_idx,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   load_req;
    logic [IDX_W-1:0]       load_idx;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       last_idx;
    logic                   loop_mode;
    logic                   dither_run;
    logic                   stop_pend;
    logic [DWELL_WIDTH-1:0] cnt;
    logic [WIDTH-1:0]       step_hold;
    logic [WIDTH-1:0]       step_mem  [DEPTH];
    logic [DWELL_WIDTH-1:0] dwell_mem [DEPTH];

    // Hop table storage; deliberately not reset so contents survive a reset.
    always_ff @(posedge aclk) begin
        if (cfg_wr_en) begin
            step_mem[cfg_wr_addr]  <= cfg_wr_step;
            dwell_mem[cfg_wr_addr] <= cfg_wr_dwell;
        end
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load_req/load_idx select the entry to fetch into LOAD.
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        load_idx   = idx;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = LOAD;
                    load_req   = 1'b1;
                    load_idx   = '0;
                end
            end
            LOAD: begin
                if (m_axis_data_tready) begin
                    state_next = (stop || stop_pend) ? IDLE : DWELL;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (cnt <= DWELL_WIDTH'(1)) begin
                    if (idx != last_idx) begin
                        state_next = LOAD;
                        load_req   = 1'b1;
                        load_idx   = idx + IDX_W'(1);
                    end else if (loop_mode) begin
                        state_next = LOAD;
                        load_req   = 1'b1;
                        load_idx   = '0;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Run datapath: captured run config, active entry, dwell counter, pending stop.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            idx        <= '0;
            last_idx   <= '0;
            loop_mode  <= 1'b0;
            dither_run <= 1'b0;
            stop_pend  <= 1'b0;
            cnt        <= '0;
            step_hold  <= '0;
        end else begin
            if (state == IDLE && start && !stop) begin
                last_idx   <= cfg_last_idx;
                loop_mode  <= cfg_loop;
                dither_run <= cfg_dither;
            end
            if (load_req) begin
                idx       <= load_idx;
                step_hold <= step_mem[load_idx];
                cnt       <= (dwell_mem[load_idx] == '0) ? DWELL_WIDTH'(1)
                                                         : dwell_mem[load_idx];
            end else if (state == DWELL) begin
                cnt <= cnt - DWELL_WIDTH'(1);
            end
            if (state_next != LOAD) begin
                stop_pend <= 1'b0;
            end else if (state == LOAD && stop) begin
                stop_pend <= 1'b1;
            end
        end
    end

    // Output decode; a stop arriving in DONE suppresses the done pulse.
    always_comb begin
        m_axis_data_tdata  = step_hold;
        m_axis_data_tvalid = (state == LOAD);
        busy               = (state != IDLE);
        dither_enable      = (state != IDLE) && dither_run;
        cur_idx            = idx;
        done               = (state == DONE) && !stop;
    end

endmodule

// File: tb/tb_nco_hop_sequencer.sv
// tb_nco_hop_sequencer: directed self-checking bench with a scoreboard of
// expected step words popped on every AXI-Stream handshake.
module tb_nco_hop_sequencer;

    localparam int WIDTH       = 32;
    localparam int DEPTH       = 16;
    localparam int DWELL_WIDTH = 24;
    localparam int IDX_W       = 4;

    logic                   aclk = 1'b0;
    logic                   arst_n;
    logic                   cfg_wr_en;
    logic [IDX_W-1:0]       cfg_wr_addr;
    logic [WIDTH-1:0]       cfg_wr_step;
    logic [DWELL_WIDTH-1:0] cfg_wr_dwell;
    logic [IDX_W-1:0]       cfg_last_idx;
    logic                   cfg_loop;
    logic                   cfg_dither;
    logic                   start;
    logic                   stop;
    logic [WIDTH-1:0]       m_axis_data_tdata;
    logic                   m_axis_data_tvalid;
    logic                   m_axis_data_tready;
    logic                   dither_enable;
    logic                   busy;
    logic [IDX_W-1:0]       cur_idx;
    logic                   done;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    nco_hop_sequencer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .DWELL_WIDTH(DWELL_WIDTH)
    ) dut (
        .aclk(aclk),
        .arst_n(arst_n),
        .cfg_wr_en(cfg_wr_en),
        .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_step(cfg_wr_step),
        .cfg_wr_dwell(cfg_wr_dwell),
        .cfg_last_idx(cfg_last_idx),
        .cfg_loop(cfg_loop),
        .cfg_dither(cfg_dither),
        .start(start),
        .stop(stop),
        .m_axis_data_tdata(m_axis_data_tdata),
        .m_axis_data_tvalid(m_axis_data_tvalid),
        .m_axis_data_tready(m_axis_data_tready),
        .dither_enable(dither_enable),
        .busy(busy),
        .cur_idx(cur_idx),
        .done(done)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic writeEntry(input int addr, input logic [31:0] step, input int dwell);
        cfg_wr_en    = 1'b1;
        cfg_wr_addr  = IDX_W'(addr);
        cfg_wr_step  = step;
        cfg_wr_dwell = DWELL_WIDTH'(dwell);
        tick();
        cfg_wr_en    = 1'b0;
    endtask

    task automatic pushExp(input int i, input logic [31:0] d);
        exp_t e;
        e.idx  = IDX_W'(i);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic last_start, input logic last_stop);
        start = last_start;
        stop  = last_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Scoreboard: every handshake pops the next expected word and index.
    always @(negedge aclk) begin
        if (arst_n && m_axis_data_tvalid && m_axis_data_tready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("[TB] FAIL sb_underflow observed=%h expected=none", m_axis_data_tdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_tdata", m_axis_data_tdata, e.data);
                checkOutput("sb_idx", 32'(cur_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        arst_n = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_step = '0; cfg_wr_dwell = '0;
        cfg_last_idx = '0; cfg_loop = 1'b0; cfg_dither = 1'b0;
        start = 1'b0; stop = 1'b0; m_axis_data_tready = 1'b1;

        // Table writes are accepted while reset is held.
        writeEntry(0, 32'h0100_0000, 4);
        writeEntry(1, 32'h0200_0000, 2);
        writeEntry(2, 32'h0300_0000, 1);
        checkOutput("rst_tdata", m_axis_data_tdata, 0);
        checkOutput("rst_tvalid", 32'(m_axis_data_tvalid), 0);
        checkOutput("rst_dither", 32'(dither_enable), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_idx", 32'(cur_idx), 0);
        checkOutput("rst_done", 32'(done), 0);
        arst_n = 1'b1;
        tick();

        $display("[TB] single shot");
        cfg_last_idx = 4'd2; cfg_loop = 1'b0; cfg_dither = 1'b1;
        pushExp(0, 32'h0100_0000); pushExp(1, 32'h0200_0000); pushExp(2, 32'h0300_0000);
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) cfg_dither = 1'b0;
            checkOutput("ss_tvalid", 32'(m_axis_data_tvalid), 32'(c == 1 || c == 6 || c == 9));
            checkOutput("ss_done", 32'(done), 32'(c == 11));
            checkOutput("ss_busy", 32'(busy), 32'(c <= 11));
            checkOutput("ss_dither", 32'(dither_enable), 32'(c <= 11));
            tick();
        end
        checkOutput("ss_tdata_hold", m_axis_data_tdata, 32'h0300_0000);

        $display("[TB] loop wrap");
        writeEntry(0, 32'h0A00_0000, 3);
        writeEntry(1, 32'h0B00_0000, 3);
        cfg_last_idx = 4'd1; cfg_loop = 1'b1; cfg_dither = 1'b0;
        pushExp(0, 32'h0A00_0000); pushExp(1, 32'h0B00_0000); pushExp(0, 32'h0A00_0000);
        pushExp(1, 32'h0B00_0000); pushExp(0, 32'h0A00_0000);
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            checkOutput("lp_tvalid", 32'(m_axis_data_tvalid), 32'(c % 4 == 1));
            checkOutput("lp_done", 32'(done), 0);
            checkOutput("lp_dither", 32'(dither_enable), 0);
            if (c == 18) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        checkOutput("lp_stop_busy", 32'(busy), 0);
        checkOutput("lp_stop_tvalid", 32'(m_axis_data_tvalid), 0);
        checkOutput("lp_stop_done", 32'(done), 0);
        tick();
        checkOutput("lp_stop_tvalid2", 32'(m_axis_data_tvalid), 0);

        $display("[TB] backpressure");
        cfg_last_idx = 4'd1; cfg_loop = 1'b0;
        m_axis_data_tready = 1'b0;
        pushExp(0, 32'h0A00_0000); pushExp(1, 32'h0B00_0000);
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            if (c == 6) m_axis_data_tready = 1'b1;
            checkOutput("bp_tvalid", 32'(m_axis_data_tvalid), 32'(c <= 6 || c == 10));
            if (c <= 6) checkOutput("bp_tdata", m_axis_data_tdata, 32'h0A00_0000);
            checkOutput("bp_done", 32'(done), 32'(c == 14));
            tick();
        end
        m_axis_data_tready = 1'b0;
        pushExp(0, 32'h0A00_0000);
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) stop = 1'b1;
            if (c == 4) stop = 1'b0;
            if (c == 6) m_axis_data_tready = 1'b1;
            checkOutput("bps_tvalid", 32'(m_axis_data_tvalid), 32'(c <= 6));
            checkOutput("bps_busy", 32'(busy), 32'(c <= 6));
            checkOutput("bps_done", 32'(done), 0);
            tick();
        end

        $display("[TB] dwell 0 and boundary index");
        for (int i = 0; i < DEPTH; i++) begin
            writeEntry(i, 32'h100 + 32'(i), (i == 15) ? 0 : 1);
        end
        cfg_last_idx = 4'd15; cfg_loop = 1'b1;
        for (int i = 0; i < DEPTH; i++) pushExp(i, 32'h100 + 32'(i));
        pushExp(0, 32'h100);
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 34; c++) begin
            checkOutput("d0_tvalid", 32'(m_axis_data_tvalid), 32'((c % 2 == 1) && c <= 33));
            checkOutput("d0_idx", 32'(cur_idx), 32'(((c - 1) / 2) % 16));
            if (c == 34) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        checkOutput("d0_stop_busy", 32'(busy), 0);

        $display("[TB] write hazard");
        writeEntry(0, 32'h0A00_0000, 4);
        cfg_last_idx = 4'd1; cfg_loop = 1'b1;
        pushExp(0, 32'h0A00_0000); pushExp(1, 32'h101); pushExp(0, 32'h0C00_0000);
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) begin
                cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0;
                cfg_wr_step = 32'h0C00_0000; cfg_wr_dwell = 24'd4;
            end
            if (c == 4) cfg_wr_en = 1'b0;
            checkOutput("wh_tvalid", 32'(m_axis_data_tvalid), 32'(c == 1 || c == 6 || c == 8));
            if (c <= 5) checkOutput("wh_tdata_old", m_axis_data_tdata, 32'h0A00_0000);
            if (c >= 8) checkOutput("wh_tdata_new", m_axis_data_tdata, 32'h0C00_0000);
            if (c == 9) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        checkOutput("wh_stop_busy", 32'(busy), 0);

        $display("[TB] start/stop collision and reset");
        applyStimulus(1'b1, 1'b1);
        checkOutput("col_busy", 32'(busy), 0);
        checkOutput("col_tvalid", 32'(m_axis_data_tvalid), 0);
        tick();
        checkOutput("col_busy2", 32'(busy), 0);
        cfg_loop = 1'b0; cfg_dither = 1'b1;
        m_axis_data_tready = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rl_tvalid", 32'(m_axis_data_tvalid), 1);
        arst_n = 1'b0;
        tick();
        checkOutput("rl_tdata", m_axis_data_tdata, 0);
        checkOutput("rl_tvalid0", 32'(m_axis_data_tvalid), 0);
        checkOutput("rl_dither", 32'(dither_enable), 0);
        checkOutput("rl_busy", 32'(busy), 0);
        checkOutput("rl_idx", 32'(cur_idx), 0);
        checkOutput("rl_done", 32'(done), 0);
        arst_n = 1'b1;
        m_axis_data_tready = 1'b1;
        tick();
        pushExp(0, 32'h0C00_0000); pushExp(1, 32'h101);
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            checkOutput("rp_tvalid", 32'(m_axis_data_tvalid), 32'(c == 1 || c == 6));
            checkOutput("rp_done", 32'(done), 32'(c == 8));
            checkOutput("rp_busy", 32'(busy), 32'(c <= 8));
            checkOutput("rp_dither", 32'(dither_enable), 32'(c <= 8));
            tick();
        end

        tick();
        checkOutput("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nco_hop_sequencer.md
Name: nco_hop_sequencer

Overview:
Frequency-hop / sweep controller for the NCO → MASH 1-1 → 2nd-order DSM → OSERDES upconverter chain. Holds a small table of NCO phase-step words, each with a dwell count. On start it walks the table, issuing each step word to the NCO tuning input over an AXI-Stream handshake and holding it for its dwell time, in single-shot or loop mode. Sits between the JTAG/AXI-Lite configuration path and the I/Q NCO step inputs. Also drives the NCO dither enable.

Parameters:
WIDTH, 32, NCO step word width (ACC_INT_WIDTH + ACC_FRAC_WIDTH = 8 + 24)
DEPTH, 16, number of hop table entries (power of 2, ≥2)
DWELL_WIDTH, 24, dwell counter width in aclk cycles
IDX_W, $clog2(DEPTH), table index width (derived, not overridable)

Ports:
aclk  in  1  sole clock
arst_n  in  1  reset, synchronous, active-low
cfg_wr_en  in  1  table write strobe
cfg_wr_addr  in  IDX_W  table write index
cfg_wr_step  in  WIDTH  step word for the entry
cfg_wr_dwell  in  DWELL_WIDTH  dwell cycles for the entry
cfg_last_idx  in  IDX_W  last table index of the sequence
cfg_loop  in  1  1 = wrap to index 0 after last_idx; 0 = single shot
cfg_dither  in  1  dither request applied during the run
start  in  1  start pulse
stop  in  1  abort pulse
m_axis_data_tdata  out  WIDTH  step word to the NCO
m_axis_data_tvalid  out  1  step word valid
m_axis_data_tready  in  1  NCO accept
dither_enable  out  1  NCO dither enable
busy  out  1  sequence running
cur_idx  out  IDX_W  entry currently issued or dwelling
done  out  1  one-cycle pulse at single-shot completion

Behaviour:
- Reset (arst_n = 0 at a rising edge of aclk): state IDLE.
  - All outputs are 0: tdata, tvalid, dither_enable, busy, cur_idx, done.
  - Table contents are not reset. They are undefined until written.
- Table writes:
  - Accepted in every state, including during reset release. Take effect at the next edge.
  - The active entry's step and dwell are captured into holding registers on entry to LOAD. A write to the active entry only affects its next visit.
- cfg_last_idx, cfg_loop and cfg_dither are sampled on an accepted start. They are held for the whole run.
- States:
  - IDLE:
    - start=1 and stop=0 → LOAD at idx 0. Set busy=1 and dither_enable=sampled cfg_dither.
    - start and stop in the same cycle → remain IDLE.
  - LOAD:
    - tvalid=1, tdata=step[idx], cur_idx=idx.
    - tdata stays stable while tvalid=1 and tready=0.
    - On tvalid & tready: tvalid=0 next cycle → DWELL, counter loaded with dwell[idx]. A dwell of 0 is treated as 1.
  - DWELL:
    - The counter decrements each cycle and exits after exactly max(dwell,1) cycles. Exit goes to:
      - idx < last_idx → LOAD idx+1.
      - idx == last_idx and loop=1 → LOAD idx 0.
      - idx == last_idx and loop=0 → DONE.
    - The index wraps modulo DEPTH. A cfg_last_idx ≥ DEPTH cannot occur (width-limited).
  - DONE: a single cycle. done=1, then IDLE with busy=0 and dither_enable=0. tdata holds the last issued word.
- stop:
  - In DWELL or DONE: go to IDLE next cycle. busy=0, dither_enable=0, no done pulse.
  - In LOAD with tvalid=1: the pending transfer is not withdrawn (AXI-S rule). Stop is latched and taken as soon as the handshake completes, with no DWELL.
- start while busy is ignored.
- Timing with tready held at 1: start at cycle 0 → tvalid at cycle 1 → DWELL on cycles 2..1+D → next tvalid at cycle 2+D. The per-entry period is 1+max(D,1) cycles.
- Reset mid-run: abort immediately to reset values on the next edge. The table is retained.

Test Plan:
- Single shot, tready=1:
  - Setup: write entries 0..2 = (0x0100_0000,4), (0x0200_0000,2), (0x0300_0000,1); last_idx=2, loop=0; start.
  - Required: tvalid at cycles 1, 6, 9 with the matching tdata; done pulse at cycle 11, then busy=0.
- Loop wrap: last_idx=1, loop=1, dwell 3 each → issue sequence idx 0,1,0,1,… every 4 cycles; done never asserts; stop in DWELL → busy=0 next cycle, tvalid stays 0.
- Backpressure: tready=0 for 5 cycles after the first tvalid → tvalid and tdata stable throughout; DWELL starts the cycle after tready rises; a stop during the stall is honoured only after the handshake.
- Dwell 0 and the boundary index: entry 15 dwell 0, last_idx=15, loop=1 → entry 15 dwells 1 cycle, then idx wraps to 0.
- Write hazard: rewrite the active entry's step during DWELL → the current tdata is unchanged; the new word appears on the next visit.
- Start/stop collision and reset:
  - start+stop in the same cycle → stays IDLE.
  - arst_n=0 during LOAD → all outputs 0 on the next edge; a later start replays the retained table.
